pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller that sequences the MIPS program counter register by producing its next-address input every cycle.
- Selects among reset vector, sequential increment, branch, jump and jump-register targets.
- Holds the PC under stalls, fetch back-pressure and halt.
- Buffers one redirect while fetch is blocked, and signals a fetch-stage flush on redirect.

Parameters:
- RESET_VECTOR, 32'h0000_0000, address loaded into PC after reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc  in  32  current value held by PC register
- fetch_ready  in  1  instruction memory accepts a new fetch address this cycle
- stall  in  1  hazard-unit stall request
- halt  in  1  stop fetching (e.g. decoded halt/syscall)
- branch_taken  in  1  resolved taken branch
- branch_target  in  32  branch destination
- jump  in  1  J/JAL
- jump_target  in  32  jump destination
- jr  in  1  JR
- jr_target  in  32  register destination
- next_pc  out  32  drives the PC register's next-address input; combinational from state and inputs
- flush  out  1  squash the instruction in the IF/ID register at the coming edge
- halted  out  1  registered; high in HALT
- redirect_pending  out  1  registered; high while a buffered target is held

Behaviour:
- States: BOOT, RUN, WAIT, HALT. State, the pending-target register and halted are all registered.
- Reset:
  - While reset=1: next_pc=RESET_VECTOR, flush=0.
  - At the edge: state<=BOOT, pending cleared, halted<=0, redirect_pending<=0.
  - Reset overrides every other input, in any state, including mid-WAIT.
- BOOT: next_pc=RESET_VECTOR, flush=0; go to RUN unconditionally.
- Redirect target selection:
  - redirect = jr | jump | branch_taken.
  - Priority jr > jump > branch.
  - Target bits [1:0] forced to 2'b00.
- RUN, evaluated in priority order:
  1. halt: next_pc=pc; go to HALT. Any redirect in the same cycle is discarded.
  2. redirect with fetch_ready=1 and stall=0: next_pc=target, flush=1; stay in RUN.
  3. redirect with fetch_ready=0 or stall=1: next_pc=pc, flush=0; latch target into pending; go to WAIT.
  4. stall=1 or fetch_ready=0: next_pc=pc.
  5. Otherwise: next_pc=pc+PC_STEP, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- WAIT:
  - next_pc=pc.
  - A new redirect overwrites pending (newest wins).
  - When fetch_ready=1 and stall=0: next_pc=pending, or the new target if a redirect is present that cycle; flush=1; clear pending; go to RUN.
  - halt: go to HALT and drop pending.
- HALT: next_pc=pc, flush=0, halted=1. Only reset exits.
- flush is never asserted in BOOT or HALT, and never in two consecutive cycles unless two redirects are applied back-to-back.
- Latency: a redirect applied in cycle N appears on pc after edge N; the first sequential address after reset is RESET_VECTOR+PC_STEP.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: MIPS branch-delay-slot semantics; flush is tied to 0 because the instruction after the branch executes. Redirect timing is unchanged.
- Undefined: flush behaves as described above.

Decomposition:
- Shared package pc_sequencer_pkg holds:
  - state encoding constants (BOOT=2'd0, RUN=2'd1, WAIT=2'd2, HALT=2'd3);
  - default RESET_VECTOR and PC_STEP.
- One natural sub-module, pc_target_mux: combinational priority select (jr > jump > branch) with alignment masking, outputting target and redirect.

Test Plan:
- Reset, then release with pc fed back from a PC register: next_pc sequence is 0x0, 0x4, 0x8, 0xC; flush=0 throughout.
- At pc=0x40, branch_taken=1 with target 0x100 and fetch_ready=1: next_pc=0x100 and flush=1 that cycle; the following cycle gives 0x104.
- jr (target 0x200), jump (target 0x300) and branch (target 0x400) asserted together: next_pc=0x200.
- jump to 0x80 while fetch_ready=0 for 3 cycles: pc holds, redirect_pending=1; when fetch_ready rises, next_pc=0x80, flush=1, then redirect_pending=0.
- halt at pc=0x20 with a simultaneous branch: pc stays 0x20 indefinitely and halted=1. Asserting reset gives next_pc=RESET_VECTOR and halted=0.
- pc=0xFFFF_FFFC, no events: next_pc=0x0. A branch target of 0x103 yields 0x100. With DELAY_SLOT_EN defined, the branch case keeps flush=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding, default
// parameter values and the word-alignment helper.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2,
      HALT = 2'd3
   } state_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_STEP      = 32'd4;

   // Instruction addresses are word aligned; low two bits are discarded.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Redirect target select: jr beats jump beats branch; result is word aligned.
module pc_target_mux
   import pc_sequencer_pkg::*;
(
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] target,
   output logic        redirect
);

   logic [31:0] raw;

   always_comb begin
      raw = branch_target;
      if (jump) raw = jump_target;
      if (jr)   raw = jr_target;
   end

   assign target   = word_align(raw);
   assign redirect = jr | jump | branch_taken;

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the MIPS PC register.
// Build option: DELAY_SLOT_EN (branch-delay-slot semantics, flush tied low).
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] PC_STEP      = DEF_PC_STEP
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        fetch_ready,
   input  logic        stall,
   input  logic        halt,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        flush,
   output logic        halted,
   output logic        redirect_pending
);

`ifdef DELAY_SLOT_EN
   localparam logic FLUSH_EN = 1'b0;
`else
   localparam logic FLUSH_EN = 1'b1;
`endif

   state_t      state, next_state;
   logic [31:0] pending, pending_nxt;
   logic [31:0] target;
   logic        redirect;
   logic        go;
   logic        flush_raw;

   pc_target_mux u_target_mux (
      .jr            (jr),
      .jr_target     (jr_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .target        (target),
      .redirect      (redirect)
   );

   // Fetch can take a new address only when memory is ready and nothing stalls.
   assign go = fetch_ready & ~stall;

   always_comb begin
      next_state  = state;
      pending_nxt = pending;
      next_pc     = pc;
      flush_raw   = 1'b0;
      case (state)
         BOOT: begin
            next_pc    = RESET_VECTOR;
            next_state = RUN;
         end
         RUN: begin
            if (halt) begin
               next_state = HALT;
            end else if (redirect && go) begin
               next_pc   = target;
               flush_raw = 1'b1;
            end else if (redirect) begin
               pending_nxt = target;
               next_state  = WAIT;
            end else if (go) begin
               next_pc = pc + PC_STEP;
            end
         end
         WAIT: begin
            if (halt) begin
               next_state  = HALT;
               pending_nxt = '0;
            end else if (go) begin
               next_pc     = redirect ? target : pending;
               flush_raw   = 1'b1;
               pending_nxt = '0;
               next_state  = RUN;
            end else if (redirect) begin
               pending_nxt = target;
            end
         end
         HALT: begin
            next_state = HALT;
         end
         default: begin
            next_state = BOOT;
         end
      endcase
      // Reset wins over everything, including a held redirect.
      if (reset) begin
         next_pc     = RESET_VECTOR;
         flush_raw   = 1'b0;
         next_state  = BOOT;
         pending_nxt = '0;
      end
   end

   assign flush = flush_raw & FLUSH_EN;

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= BOOT;
         pending          <= '0;
         halted           <= 1'b0;
         redirect_pending <= 1'b0;
      end else begin
         state            <= next_state;
         pending          <= pending_nxt;
         halted           <= (next_state == HALT);
         redirect_pending <= (next_state == WAIT);
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps then random traffic,
// compared against a flag-based behavioural model of the sequencing rules.
module tb_pc_sequencer;

   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam logic [31:0] STEP = 32'd4;

   logic        clock = 1'b0;
   logic        reset, fetch_ready, stall, halt, branch_taken, jump, jr;
   logic [31:0] pc, branch_target, jump_target, jr_target;
   logic [31:0] next_pc;
   logic        flush, halted, redirect_pending;

   int errors = 0;
   int checks = 0;

   // Model: booting after reset, halted, and an optional held target.
   bit          m_known = 0;
   bit          m_boot  = 0;
   bit          m_halt  = 0;
   bit          m_pend  = 0;
   logic [31:0] m_tgt   = '0;
   logic [31:0] e_next;
   logic        e_flush;
   logic [31:0] cap;

   always #5 clock = ~clock;

   pc_sequencer dut (
      .clock            (clock),
      .reset            (reset),
      .pc               (pc),
      .fetch_ready      (fetch_ready),
      .stall            (stall),
      .halt             (halt),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .jump             (jump),
      .jump_target      (jump_target),
      .jr               (jr),
      .jr_target        (jr_target),
      .next_pc          (next_pc),
      .flush            (flush),
      .halted           (halted),
      .redirect_pending (redirect_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reset = 0; fetch_ready = 1; stall = 0; halt = 0;
      branch_taken = 0; jump = 0; jr = 0;
      branch_target = '0; jump_target = '0; jr_target = '0;
   endtask

   // One clock: check outputs against the model, feed next_pc back into pc.
   task automatic cycle(input string tag);
      bit          n_boot, n_halt, n_pend;
      logic [31:0] n_tgt, tgt;
      bit          redir, can_go;
      #1;
      n_boot = m_boot; n_halt = m_halt; n_pend = m_pend; n_tgt = m_tgt;
      e_flush = 1'b0;
      e_next  = pc;
      redir   = jr | jump | branch_taken;
      tgt     = jr ? jr_target : (jump ? jump_target : branch_target);
      tgt[1:0] = 2'b00;
      can_go  = fetch_ready && !stall;
      if (reset) begin
         e_next = RV;
         n_boot = 1; n_halt = 0; n_pend = 0; n_tgt = '0;
      end else if (m_boot) begin
         e_next = RV;
         n_boot = 0;
      end else if (m_halt) begin
         e_next = pc;
      end else if (halt) begin
         n_halt = 1; n_pend = 0;
      end else if (can_go) begin
         if (redir) begin
            e_next = tgt; e_flush = 1;
         end else if (m_pend) begin
            e_next = m_tgt; e_flush = 1;
         end else begin
            e_next = pc + STEP;
         end
         n_pend = 0;
      end else if (redir) begin
         n_pend = 1; n_tgt = tgt;
      end
`ifdef DELAY_SLOT_EN
      e_flush = 1'b0;
`endif
      chk({tag, " next_pc"}, next_pc, e_next);
      chk({tag, " flush"}, {31'b0, flush}, {31'b0, e_flush});
      if (m_known) begin
         chk({tag, " halted"}, {31'b0, halted}, {31'b0, m_halt});
         chk({tag, " redirect_pending"}, {31'b0, redirect_pending}, {31'b0, m_pend});
      end
      cap = next_pc;
      @(posedge clock);
      #1;
      pc = cap;
      if (reset) m_known = 1;
      m_boot = n_boot; m_halt = n_halt; m_pend = n_pend; m_tgt = n_tgt;
      @(negedge clock);
   endtask

   initial begin
      idle();
      pc = 32'hDEAD_BEE0;
      @(negedge clock);

      // Reset and release into sequential fetch
      reset = 1;
      cycle("reset0");
      cycle("reset1");
      reset = 0;
      cycle("boot");
      for (int i = 0; i < 4; i++) cycle("seq");
      chk("seq pc", pc, 32'h10);

      // Taken branch with fetch ready
      pc = 32'h40;
      branch_taken = 1; branch_target = 32'h100;
      cycle("branch");
      branch_taken = 0;
      chk("branch pc", pc, 32'h100);
      cycle("after_branch");
      chk("after_branch pc", pc, 32'h104);

      // All three redirects together
      jr = 1; jr_target = 32'h200;
      jump = 1; jump_target = 32'h300;
      branch_taken = 1; branch_target = 32'h400;
      cycle("prio");
      idle();
      chk("prio pc", pc, 32'h200);

      // Jump buffered while fetch is blocked
      fetch_ready = 0; jump = 1; jump_target = 32'h80;
      cycle("jwait0");
      jump = 0;
      cycle("jwait1");
      cycle("jwait2");
      chk("jwait hold pc", pc, 32'h200);
      fetch_ready = 1;
      cycle("jrelease");
      chk("jrelease pc", pc, 32'h80);
      cycle("jafter");

      // Halt beats a simultaneous branch
      pc = 32'h20;
      halt = 1; branch_taken = 1; branch_target = 32'h500;
      cycle("halt");
      idle();
      for (int i = 0; i < 3; i++) cycle("halted");
      chk("halt pc", pc, 32'h20);
      chk("halt flag", {31'b0, halted}, 32'd1);
      reset = 1;
      cycle("halt_reset");
      reset = 0;
      chk("unhalt flag", {31'b0, halted}, 32'd0);
      cycle("boot2");

      // Address wrap and target alignment
      pc = 32'hFFFF_FFFC;
      cycle("wrap");
      chk("wrap pc", pc, 32'h0);
      branch_taken = 1; branch_target = 32'h103;
      cycle("align");
      idle();
      chk("align pc", pc, 32'h100);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         reset         = ($urandom_range(0, 39) == 0);
         halt          = ($urandom_range(0, 29) == 0);
         fetch_ready   = ($urandom_range(0, 3) != 0);
         stall         = ($urandom_range(0, 4) == 0);
         branch_taken  = ($urandom_range(0, 6) == 0);
         jump          = ($urandom_range(0, 7) == 0);
         jr            = ($urandom_range(0, 8) == 0);
         branch_target = $urandom;
         jump_target   = $urandom;
         jr_target     = $urandom;
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
